// File: rtl/bus_pkg.sv
// ----------------------------------------------------------------------------
// bus_pkg
// Purpose : shared types and constants for the QSPI port arbiter.
//   owner_t : which master owns the current transaction (I, D or U)
//   state_t : arbiter sequencer states
//   SZ_*    : access size encoding as {w, hw}
// ----------------------------------------------------------------------------
package bus_pkg;

    typedef enum logic [1:0] {
        OWN_I = 2'd0,
        OWN_D = 2'd1,
        OWN_U = 2'd2
    } owner_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Size encoding {w, hw}: byte when both are clear.
    localparam logic [1:0] SZ_B  = 2'b00;
    localparam logic [1:0] SZ_HW = 2'b01;
    localparam logic [1:0] SZ_W  = 2'b10;

endpackage

// File: rtl/bus_arb_pick.sv
// ----------------------------------------------------------------------------
// bus_arb_pick
// Purpose : combinational owner selection for the QSPI port.
//   U has strict priority; I and D share the port round-robin, the master
//   that did not own the last I/D transaction wins a tie. Within D and U a
//   write beats a read; the read simply stays pending.
// Ports:
//   i_i_req            I read request
//   i_d_rd / i_d_wr    D read / write request
//   i_u_rd / i_u_wr    U read / write request
//   i_rr_last          last I/D owner served
//   o_owner            selected owner
//   o_valid            some request is pending
//   o_we               selected transaction is a write
// ----------------------------------------------------------------------------
module bus_arb_pick
    import bus_pkg::*;
(
    input  logic   i_i_req,
    input  logic   i_d_rd,
    input  logic   i_d_wr,
    input  logic   i_u_rd,
    input  logic   i_u_wr,
    input  owner_t i_rr_last,
    output owner_t o_owner,
    output logic   o_valid,
    output logic   o_we
);

    logic w_d_any;
    logic w_u_any;

    assign w_d_any = i_d_rd | i_d_wr;
    assign w_u_any = i_u_rd | i_u_wr;

    // Priority / round-robin owner selection.
    always_comb begin
        o_owner = OWN_I;
        o_valid = 1'b0;
        o_we    = 1'b0;
        if (w_u_any) begin
            o_owner = OWN_U;
            o_valid = 1'b1;
            o_we    = i_u_wr;
        end else if (i_i_req && w_d_any) begin
            o_valid = 1'b1;
            if (i_rr_last == OWN_I) begin
                o_owner = OWN_D;
                o_we    = i_d_wr;
            end else begin
                o_owner = OWN_I;
                o_we    = 1'b0;
            end
        end else if (i_i_req) begin
            o_owner = OWN_I;
            o_valid = 1'b1;
            o_we    = 1'b0;
        end else if (w_d_any) begin
            o_owner = OWN_D;
            o_valid = 1'b1;
            o_we    = i_d_wr;
        end else begin
            o_owner = OWN_I;
            o_valid = 1'b0;
            o_we    = 1'b0;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// ----------------------------------------------------------------------------
// bus_arbiter
// Purpose : sequences the single QSPI memory port among instruction fetch (I),
//   CPU load/store (D) and UART debug loader (U). One transaction at a time:
//   grant, latch command, one-cycle q_start, wait for q_done (or timeout),
//   one-cycle done/rdata/err back to the owner. All outputs are registered.
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   i_read_req/_w/_hw/_adr         I read request, size, address
//   d_read_req/d_write_req         D requests; d_w/d_hw size; d_adr, d_wdata
//   u_read_req/u_write_req         U requests (word); u_adr, u_wdata
//   i_done/d_done/u_done           one-cycle completion pulse per master
//   rdata, err                     read data / timeout flag, valid with done
//   q_start, q_we, q_w, q_hw       command to QSPI controller
//   q_adr, q_wdata                 address / write data to QSPI controller
//   q_done, q_rdata                completion and read data from QSPI
// ----------------------------------------------------------------------------
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int TO_CYCLES = 4096,
    parameter int TO_W      = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_read_req,
    input  logic        i_read_w,
    input  logic        i_read_hw,
    input  logic [31:0] i_read_adr,
    input  logic        d_read_req,
    input  logic        d_write_req,
    input  logic        d_w,
    input  logic        d_hw,
    input  logic [31:0] d_adr,
    input  logic [31:0] d_wdata,
    input  logic        u_read_req,
    input  logic        u_write_req,
    input  logic [31:0] u_adr,
    input  logic [31:0] u_wdata,
    output logic        i_done,
    output logic        d_done,
    output logic        u_done,
    output logic [31:0] rdata,
    output logic        err,
    output logic        q_start,
    output logic        q_we,
    output logic        q_w,
    output logic        q_hw,
    output logic [31:0] q_adr,
    output logic [31:0] q_wdata,
    input  logic        q_done,
    input  logic [31:0] q_rdata
);

    state_t            r_state;
    owner_t            r_owner;
    owner_t            r_rr_last;
    logic [TO_W-1:0]   r_cnt;
    logic              r_i_done, r_d_done, r_u_done, r_err, r_q_start;
    logic              r_q_we, r_q_w, r_q_hw;
    logic [31:0]       r_rdata, r_q_adr, r_q_wdata;

    owner_t            w_pick_owner;
    logic              w_pick_valid;
    logic              w_pick_we;
    logic [1:0]        w_size;
    logic [31:0]       w_adr;
    logic [31:0]       w_wdata;

    bus_arb_pick u_pick (
        .i_i_req   (i_read_req),
        .i_d_rd    (d_read_req),
        .i_d_wr    (d_write_req),
        .i_u_rd    (u_read_req),
        .i_u_wr    (u_write_req),
        .i_rr_last (r_rr_last),
        .o_owner   (w_pick_owner),
        .o_valid   (w_pick_valid),
        .o_we      (w_pick_we)
    );

    // Command fields of the selected master; U is always a word access.
    always_comb begin
        w_size  = SZ_B;
        w_adr   = 32'd0;
        w_wdata = 32'd0;
        case (w_pick_owner)
            OWN_I: begin
                w_size  = {i_read_w, i_read_hw};
                w_adr   = i_read_adr;
                w_wdata = 32'd0;
            end
            OWN_D: begin
                w_size  = {d_w, d_hw};
                w_adr   = d_adr;
                w_wdata = w_pick_we ? d_wdata : 32'd0;
            end
            OWN_U: begin
                w_size  = SZ_W;
                w_adr   = u_adr;
                w_wdata = w_pick_we ? u_wdata : 32'd0;
            end
            default: begin
                w_size  = SZ_B;
                w_adr   = 32'd0;
                w_wdata = 32'd0;
            end
        endcase
    end

    // Transaction sequencer with latched command and registered responses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_owner   <= OWN_I;
            r_rr_last <= OWN_D;
            r_cnt     <= '0;
            r_i_done  <= 1'b0;
            r_d_done  <= 1'b0;
            r_u_done  <= 1'b0;
            r_err     <= 1'b0;
            r_rdata   <= 32'd0;
            r_q_start <= 1'b0;
            r_q_we    <= 1'b0;
            r_q_w     <= 1'b0;
            r_q_hw    <= 1'b0;
            r_q_adr   <= 32'd0;
            r_q_wdata <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_owner   <= w_pick_owner;
                        r_q_we    <= w_pick_we;
                        r_q_w     <= w_size[1];
                        r_q_hw    <= w_size[0];
                        r_q_adr   <= w_adr;
                        r_q_wdata <= w_wdata;
                        r_q_start <= 1'b1;
                        r_state   <= ST_START;
                    end
                end
                ST_START: begin
                    // Any q_done seen here belongs to nothing and is dropped.
                    r_q_start <= 1'b0;
                    r_cnt     <= '0;
                    r_state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (q_done) begin
                        r_rdata  <= r_q_we ? 32'd0 : q_rdata;
                        r_err    <= 1'b0;
                        r_i_done <= (r_owner == OWN_I);
                        r_d_done <= (r_owner == OWN_D);
                        r_u_done <= (r_owner == OWN_U);
                        r_state  <= ST_RESP;
                    end else if (r_cnt == TO_W'(TO_CYCLES - 1)) begin
                        r_rdata  <= 32'd0;
                        r_err    <= 1'b1;
                        r_i_done <= (r_owner == OWN_I);
                        r_d_done <= (r_owner == OWN_D);
                        r_u_done <= (r_owner == OWN_U);
                        r_state  <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + TO_W'(1);
                    end
                end
                ST_RESP: begin
                    r_i_done <= 1'b0;
                    r_d_done <= 1'b0;
                    r_u_done <= 1'b0;
                    r_err    <= 1'b0;
                    r_rdata  <= 32'd0;
                    // Round-robin history only tracks the I/D pair; U is absolute.
                    if (r_owner != OWN_U) begin
                        r_rr_last <= r_owner;
                    end
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign i_done  = r_i_done;
    assign d_done  = r_d_done;
    assign u_done  = r_u_done;
    assign rdata   = r_rdata;
    assign err     = r_err;
    assign q_start = r_q_start;
    assign q_we    = r_q_we;
    assign q_w     = r_q_w;
    assign q_hw    = r_q_hw;
    assign q_adr   = r_q_adr;
    assign q_wdata = r_q_wdata;

endmodule
